mix64_round_sequencer: RTL and testbench

- Iterative sequencer for the 64-bit keyed mixing datapath: one mix round per clock, over a programmable round-constant table.
- Each round computes xor constant, then add constant, then multiply constant, then rotate right.
- Sits between a request source (valid/ready) and a result sink (valid/ready). The config port programs per-round constants while idle.

---
 rtl/mix64_round_sequencer.sv | 120 ++++++++++++
 tb/tb_mix64_round_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mix64_round_sequencer.sv
// Iterative 64-bit keyed mixer. Each accepted job runs ROUNDS rounds, one per clock:
// xor, add, multiply, rotate-right. The constants come from a table that is programmed while idle.
module mix64_round_sequencer #(
  parameter int ROUNDS = 8,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [4:0]       cfg_addr,
  input  logic [63:0]      cfg_wdata,
  output logic             cfg_ready,
  output logic             cfg_err,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

  localparam logic [2:0] LAST = 3'(ROUNDS - 1);

  state_e           st_q, st_d;
  logic [63:0]      s_q, s_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             cfg_err_q;

  // The table is always 8 deep, so cnt_q never needs a range check; writes are limited to ROUNDS.
  logic [7:0][63:0] x_q, a_q, m_q;
  logic [7:0][5:0]  r_q;

  logic        idle, cfg_ok;
  logic [2:0]  cfg_idx;
  logic [63:0] mix_t, round_out;
  logic [127:0] rot_w;

  assign idle      = (st_q == IDLE);
  assign cfg_idx   = cfg_addr[4:2];
  assign cfg_ok    = cfg_we && idle && (int'(cfg_idx) < ROUNDS);
  assign in_ready  = idle;
  assign cfg_ready = idle;
  assign busy      = !idle;
  assign cfg_err   = cfg_err_q;
  assign out_valid = (st_q == DONE);
  assign out_data  = out_valid ? s_q : '0;
  assign out_tag   = out_valid ? tag_q : '0;

  // A doubled word shifted right gives the rotation directly; R = 0 leaves t unchanged.
  always_comb begin
    mix_t     = ((s_q ^ x_q[cnt_q]) + a_q[cnt_q]) * m_q[cnt_q];
    rot_w     = {mix_t, mix_t} >> r_q[cnt_q];
    round_out = rot_w[63:0];
  end

  always_comb begin
    st_d  = st_q;
    s_d   = s_q;
    tag_d = tag_q;
    cnt_d = cnt_q;
    unique case (st_q)
      IDLE: if (in_valid) begin
        s_d   = in_data;
        tag_d = in_tag;
        cnt_d = '0;
        st_d  = RUN;
      end
      RUN: begin
        s_d   = round_out;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == LAST) st_d = DONE;
      end
      DONE: if (out_ready) st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= IDLE;
      s_q       <= '0;
      tag_q     <= '0;
      cnt_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      st_q      <= st_d;
      s_q       <= s_d;
      tag_q     <= tag_d;
      cnt_q     <= cnt_d;
      cfg_err_q <= cfg_we && !cfg_ok;
    end
  end

  // One register row per round. The reset value is the identity round.
  for (genvar g = 0; g < 8; g++) begin : g_row
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        x_q[g] <= '0;
        a_q[g] <= '0;
        m_q[g] <= 64'd1;
        r_q[g] <= '0;
      end else if (cfg_ok && cfg_idx == 3'(g)) begin
        unique case (cfg_addr[1:0])
          2'd0: x_q[g] <= cfg_wdata;
          2'd1: a_q[g] <= cfg_wdata;
          2'd2: m_q[g] <= cfg_wdata;
          2'd3: r_q[g] <= cfg_wdata[5:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mix64_round_sequencer.sv
// Bench for mix64_round_sequencer: directed vectors plus random tables and jobs checked against a reference model.
module tb_mix64_round_sequencer;
  localparam int ROUNDS = 8;
  localparam int TAG_W  = 4;

  logic             clk, rst_n;
  logic             cfg_we;
  logic [4:0]       cfg_addr;
  logic [63:0]      cfg_wdata;
  logic             cfg_ready, cfg_err;
  logic             in_valid, in_ready;
  logic [63:0]      in_data;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid, out_ready;
  logic [63:0]      out_data;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  mix64_round_sequencer #(.ROUNDS(ROUNDS), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [63:0] mx[8], ma[8], mm[8];
  int          mr[8];

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      mx[i] = '0; ma[i] = '0; mm[i] = 64'd1; mr[i] = 0;
    end
  endtask

  task automatic model_set(input int rnd, input int fld, input logic [63:0] d);
    case (fld)
      0: mx[rnd] = d;
      1: ma[rnd] = d;
      2: mm[rnd] = d;
      default: mr[rnd] = int'(d[5:0]);
    endcase
  endtask

  function automatic logic [63:0] model(input logic [63:0] d);
    logic [63:0] s, t;
    s = d;
    for (int i = 0; i < ROUNDS; i++) begin
      t = ((s ^ mx[i]) + ma[i]) * mm[i];
      s = (mr[i] == 0) ? t : ((t >> mr[i]) | (t << (64 - mr[i])));
    end
    return s;
  endfunction

  // Every task starts and ends 1 time unit after a rising edge.
  task automatic do_reset();
    rst_n = 1'b0; cfg_we = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic cfg_write(input int rnd, input int fld, input logic [63:0] d, output logic err);
    logic [2:0] r3;
    logic [1:0] f2;
    r3 = rnd[2:0];
    f2 = fld[1:0];
    cfg_we = 1'b1; cfg_addr = {r3, f2}; cfg_wdata = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    err = cfg_err;
  endtask

  task automatic run_job(input logic [63:0] d, input logic [TAG_W-1:0] t,
                         output logic [63:0] od, output logic [TAG_W-1:0] ot, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
    in_valid = 1'b1; in_data = d; in_tag = t;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    if (!out_valid) lat = -1;
    od = out_data; ot = out_tag;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 64'd0 || out_tag !== '0 || cfg_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b data=%h tag=%h err=%b busy=%b, want all zero",
               out_valid, out_data, out_tag, cfg_err, busy);
    end
    checks++;
    if (in_ready !== 1'b1 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got in_ready=%b cfg_ready=%b, want 1 1", in_ready, cfg_ready);
    end
  endtask

  task automatic test_identity();
    logic [63:0] od; logic [TAG_W-1:0] ot; int lat;
    run_job(64'h0123456789abcdef, 4'h5, od, ot, lat);
    checks++;
    if (od !== 64'h0123456789abcdef) begin
      errors++; $display("FAIL identity_data: got %h want 0123456789abcdef", od);
    end
    checks++;
    if (ot !== 4'h5) begin errors++; $display("FAIL identity_tag: got %h want 5", ot); end
    checks++;
    if (lat !== ROUNDS) begin errors++; $display("FAIL identity_latency: got %0d want %0d", lat, ROUNDS); end
  endtask

  task automatic test_add();
    logic [63:0] od; logic [TAG_W-1:0] ot; int lat; logic err;
    for (int i = 0; i < ROUNDS; i++) begin
      cfg_write(i, 1, 64'd1, err);
      model_set(i, 1, 64'd1);
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL add_cfg_err: round %0d got %b want 0", i, err); end
    end
    run_job(64'h5, 4'h1, od, ot, lat);
    checks++;
    if (od !== 64'hd) begin errors++; $display("FAIL add_small: got %h want d", od); end
    run_job(64'hffffffffffffffff, 4'h2, od, ot, lat);
    checks++;
    if (od !== 64'h7) begin errors++; $display("FAIL add_wrap: got %h want 7", od); end
  endtask

  task automatic test_rotate();
    logic [63:0] od; logic [TAG_W-1:0] ot; int lat; logic err;
    do_reset();
    cfg_write(0, 3, 64'd4, err);
    run_job(64'h1, 4'h3, od, ot, lat);
    checks++;
    if (od !== 64'h1000000000000000) begin errors++; $display("FAIL rot4: got %h want 1000000000000000", od); end
    cfg_write(0, 3, 64'd63, err);
    run_job(64'h1, 4'h3, od, ot, lat);
    checks++;
    if (od !== 64'h2) begin errors++; $display("FAIL rot63: got %h want 2", od); end
    // Only the low six bits of a rotate write are kept: this one stores 4.
    cfg_write(0, 3, 64'hffffffffffffffc4, err);
    run_job(64'h1, 4'h3, od, ot, lat);
    checks++;
    if (od !== 64'h1000000000000000) begin errors++; $display("FAIL rot_trunc: got %h want 1000000000000000", od); end
  endtask

  task automatic test_mixed();
    logic [63:0] od; logic [TAG_W-1:0] ot; int lat; logic err;
    do_reset();
    cfg_write(0, 2, 64'd3, err);
    cfg_write(1, 0, 64'hff, err);
    run_job(64'h2, 4'h9, od, ot, lat);
    checks++;
    if (od !== 64'hf9) begin errors++; $display("FAIL mixed: got %h want f9", od); end
  endtask

  task automatic test_random();
    logic [63:0] od, d, exp; logic [TAG_W-1:0] ot, t; int lat; logic err;
    int rnd, fld;
    do_reset();
    for (int it = 0; it < 30; it++) begin
      for (int k = 0; k < 3; k++) begin
        rnd = int'($urandom_range(0, ROUNDS - 1));
        fld = int'($urandom_range(0, 3));
        d   = {$urandom, $urandom};
        if (fld == 2 && $urandom_range(0, 1) == 0) d = d | 64'd1;
        cfg_write(rnd, fld, d, err);
        model_set(rnd, fld, d);
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL random_cfg_err: got %b want 0", err); end
      end
      d = {$urandom, $urandom};
      t = TAG_W'($urandom);
      exp = model(d);
      run_job(d, t, od, ot, lat);
      checks++;
      if (od !== exp || ot !== t || lat !== ROUNDS) begin
        errors++;
        $display("FAIL random_job %0d: got data=%h tag=%h lat=%0d want data=%h tag=%h lat=%0d",
                 it, od, ot, lat, exp, t, ROUNDS);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] d, exp; int w;
    d = {$urandom, $urandom};
    exp = model(d);
    in_valid = 1'b1; in_data = d; in_tag = 4'ha;
    @(posedge clk); #1;
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 50) begin @(posedge clk); #1; w++; end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp || out_tag !== 4'ha || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure cyc %0d: got valid=%b data=%h tag=%h in_ready=%b want 1 %h a 0",
                 c, out_valid, out_data, out_tag, in_ready, exp);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL backpressure_release: got valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_cfg_lockout();
    logic err; int w;
    do_reset();
    in_valid = 1'b1; in_data = 64'h00000000cafef00d; in_tag = 4'h7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (cfg_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL lockout_ready: got cfg_ready=%b busy=%b want 0 1", cfg_ready, busy);
    end
    cfg_write(0, 1, 64'h55, err);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL lockout_err: got %b want 1", err); end
    @(posedge clk); #1;
    checks++;
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL lockout_pulse: got %b want 0", cfg_err); end
    w = 0;
    while (!out_valid && w < 50) begin @(posedge clk); #1; w++; end
    checks++;
    if (out_data !== 64'h00000000cafef00d) begin
      errors++; $display("FAIL lockout_table: got %h want 00000000cafef00d", out_data);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int acc[$]; int w;
    do_reset();
    in_valid = 1'b1; in_data = 64'h1; in_tag = 4'h1; out_ready = 1'b1;
    for (int c = 0; c < 40 && acc.size() < 2; c++) begin
      if (in_ready) acc.push_back(c);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    w = 0;
    while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
    out_ready = 1'b0;
    checks++;
    if (acc.size() != 2) begin
      errors++; $display("FAIL b2b_accepts: got %0d want 2", acc.size());
    end else if (acc[1] - acc[0] != ROUNDS + 2) begin
      errors++; $display("FAIL b2b_interval: got %0d want %0d", acc[1] - acc[0], ROUNDS + 2);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [63:0] od; logic [TAG_W-1:0] ot; int lat; logic err;
    do_reset();
    cfg_write(0, 0, 64'hdead, err);
    cfg_write(2, 2, 64'd7, err);
    in_valid = 1'b1; in_data = 64'h77; in_tag = 4'h3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset: got valid=%b in_ready=%b busy=%b want 0 1 0", out_valid, in_ready, busy);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    run_job(64'h1234, 4'h6, od, ot, lat);
    checks++;
    if (od !== 64'h1234 || ot !== 4'h6) begin
      errors++; $display("FAIL midrun_identity: got data=%h tag=%h want 1234 6", od, ot);
    end
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    in_valid = 1'b0; in_data = '0; in_tag = '0; out_ready = 1'b0;
    model_reset();
    do_reset();
    test_reset();
    test_identity();
    test_add();
    test_rotate();
    test_mixed();
    test_random();
    test_backpressure();
    test_cfg_lockout();
    test_back_to_back();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
